// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared state encoding and size helpers for the argmax stream block
package argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Beats needed to carry n scores at the given lanes per beat.
  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Low bit position of lane k in a bus of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// rtl/argmax_lane_tree.sv - combinational max-and-offset reduction across the lanes of one beat
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int NUM_SIZE   = 26,
  parameter int LANES      = 4,
  parameter int SIGNED_CMP = 1,
  parameter int OFF_W      = idx_w(LANES)
) (
  input  logic [NUM_SIZE*LANES-1:0] beat_data,
  input  logic [LANES-1:0]          lane_en,
  output logic [NUM_SIZE-1:0]       beat_max,
  output logic [OFF_W-1:0]          beat_off
);

  function automatic logic gt(input logic [NUM_SIZE-1:0] a, input logic [NUM_SIZE-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

  // Ascending scan with strict greater-than keeps the lowest lane on ties;
  // disabled lanes (padding past the last class) never win.
  always_comb begin
    beat_max = beat_data[lane_lo(0, NUM_SIZE) +: NUM_SIZE];
    beat_off = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k] && gt(beat_data[lane_lo(k, NUM_SIZE) +: NUM_SIZE], beat_max)) begin
        beat_max = beat_data[lane_lo(k, NUM_SIZE) +: NUM_SIZE];
        beat_off = OFF_W'(k);
      end
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming argmax over multi-beat score vectors with ready/valid handshakes
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int  NUM_SIZE    = 26,
  parameter int  NUM_CLASSES = 10,
  parameter int  LANES       = 4,
  parameter int  SIGNED_CMP  = 1,
  localparam int IDX_W       = idx_w(NUM_CLASSES)
) (
  input  logic                      Clk,
  input  logic                      GlobalReset,
  input  logic                      Clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SIZE*LANES-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_index,
  output logic [NUM_SIZE-1:0]       out_max
);

  localparam int BEATS  = beats(NUM_CLASSES, LANES);
  localparam int BEAT_W = idx_w(BEATS);
  localparam int OFF_W  = idx_w(LANES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [NUM_SIZE-1:0] max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rdy_en_q;

  logic [LANES-1:0]    lane_en;
  logic [NUM_SIZE-1:0] tree_max;
  logic [OFF_W-1:0]    tree_off;
  logic [IDX_W-1:0]    cand_idx;
  logic                accept;

  function automatic logic gt(input logic [NUM_SIZE-1:0] a, input logic [NUM_SIZE-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

  // Enable only lanes that map to a real class in the current beat.
  always_comb begin
    lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = (int'(beat_q) * LANES + k) < NUM_CLASSES;
    end
  end

  argmax_lane_tree #(
    .NUM_SIZE  (NUM_SIZE),
    .LANES     (LANES),
    .SIGNED_CMP(SIGNED_CMP),
    .OFF_W     (OFF_W)
  ) u_lane_tree (
    .beat_data(in_data),
    .lane_en  (lane_en),
    .beat_max (tree_max),
    .beat_off (tree_off)
  );

  assign cand_idx  = IDX_W'(int'(beat_q) * LANES + int'(tree_off));
  assign accept    = in_valid && in_ready;
  assign in_ready  = rdy_en_q && (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign out_index = idx_q;
  assign out_max   = max_q;

  // Next-state and running-max fold; Clear overrides everything else.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    max_d   = max_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          max_d = tree_max;
          idx_d = cand_idx;
          if (BEATS == 1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
            beat_d  = BEAT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          // Strict compare keeps the earlier class on a tie across beats.
          if (gt(tree_max, max_q)) begin
            max_d = tree_max;
            idx_d = cand_idx;
          end
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
    if (Clear) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      max_d   = '0;
      idx_d   = '0;
    end
  end

  // State and datapath registers; ready enable rises on the first edge after reset.
  always_ff @(posedge Clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// tb/tb_argmax_stream.sv - directed self-checking bench for argmax_stream
module tb_argmax_stream;

  localparam int NS = 26;
  localparam int NL = 4;
  localparam int IW = 4;

  logic              Clk;
  logic              GlobalReset;
  logic              Clear;
  logic              in_valid;
  logic [NS*NL-1:0]  in_data;
  logic              out_ready;

  logic              s_in_ready, s_out_valid;
  logic [IW-1:0]     s_out_index;
  logic [NS-1:0]     s_out_max;
  logic              u_in_ready, u_out_valid;
  logic [IW-1:0]     u_out_index;
  logic [NS-1:0]     u_out_max;

  int checks = 0;
  int errors = 0;
  int vec [12];

  argmax_stream #(.NUM_SIZE(NS), .NUM_CLASSES(10), .LANES(NL), .SIGNED_CMP(1)) dut_s (
    .Clk(Clk), .GlobalReset(GlobalReset), .Clear(Clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_index(s_out_index), .out_max(s_out_max)
  );

  argmax_stream #(.NUM_SIZE(NS), .NUM_CLASSES(10), .LANES(NL), .SIGNED_CMP(0)) dut_u (
    .Clk(Clk), .GlobalReset(GlobalReset), .Clear(Clear),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .out_index(u_out_index), .out_max(u_out_max)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [NS-1:0] m26(input int v);
    logic [31:0] t;
    t = v;
    return t[NS-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_beat(input int v[12], input int b);
    for (int k = 0; k < NL; k++) in_data[NS*k +: NS] = m26(v[b*NL + k]);
  endtask

  task automatic send_vec(input int v[12], input int nb);
    for (int b = 0; b < nb; b++) begin
      int n;
      put_beat(v, b);
      in_valid = 1'b1;
      n = 0;
      while (!s_in_ready && n < 50) begin
        @(posedge Clk); #1;
        n++;
      end
      if (n >= 50) chk("ready_timeout", 64'(s_in_ready), 64'(1));
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 64'(s_out_valid), 64'(0));
    chk("ready_back", 64'(s_in_ready), 64'(1));
  endtask

  initial begin
    GlobalReset = 1'b0;
    Clear       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", 64'(s_in_ready), 64'(0));
    chk("rst_out_valid", 64'(s_out_valid), 64'(0));
    chk("rst_out_index", 64'(s_out_index), 64'(0));
    chk("rst_out_max", 64'(s_out_max), 64'(0));
    GlobalReset = 1'b1;
    chk("rel_in_ready_pre", 64'(s_in_ready), 64'(0));
    @(posedge Clk); #1;
    chk("rel_in_ready", 64'(s_in_ready), 64'(1));

    // Basic vector, result one cycle after the third beat.
    vec = '{5, -3, 7, 7, 2, -8, 0, 1, 9, 4, 0, 0};
    send_vec(vec, 3);
    chk("basic_valid", 64'(s_out_valid), 64'(1));
    chk("basic_index", 64'(s_out_index), 64'(8));
    chk("basic_max", 64'(s_out_max), 64'(m26(9)));
    chk("basic_in_ready", 64'(s_in_ready), 64'(0));
    chk("basic_u_index", 64'(u_out_index), 64'(1));
    take_out();

    // All equal: lowest index wins.
    vec = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 0};
    send_vec(vec, 3);
    chk("tie_all_index", 64'(s_out_index), 64'(0));
    chk("tie_all_max", 64'(s_out_max), 64'(m26(-1)));
    take_out();

    // Tie across beats: class 3 beats class 6.
    vec = '{1, 2, 3, 100, 5, 6, 100, -7, 8, 9, 0, 0};
    send_vec(vec, 3);
    chk("tie_x_index", 64'(s_out_index), 64'(3));
    chk("tie_x_max", 64'(s_out_max), 64'(m26(100)));
    take_out();

    // Padding lanes carry the largest positive value and must be ignored.
    vec = '{-5, -2, -9, -4, -7, -3, -6, -8, 0, -1, 33554431, 33554431};
    send_vec(vec, 3);
    chk("pad_index", 64'(s_out_index), 64'(8));
    chk("pad_max", 64'(s_out_max), 64'(0));
    take_out();

    // Backpressure: result held, input stalled while a new beat waits.
    vec = '{5, -3, 7, 7, 2, -8, 0, 1, 9, 4, 0, 0};
    send_vec(vec, 3);
    vec = '{1, 2, 3, 100, 5, 6, 100, -7, 8, 9, 0, 0};
    put_beat(vec, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(s_out_valid), 64'(1));
      chk("bp_index", 64'(s_out_index), 64'(8));
      chk("bp_max", 64'(s_out_max), 64'(m26(9)));
      chk("bp_in_ready", 64'(s_in_ready), 64'(0));
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_accept_in_ready", 64'(s_in_ready), 64'(0));
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk("bp_after_valid", 64'(s_out_valid), 64'(0));
    chk("bp_after_ready", 64'(s_in_ready), 64'(1));
    send_vec(vec, 3);
    chk("bp_next_valid", 64'(s_out_valid), 64'(1));
    chk("bp_next_index", 64'(s_out_index), 64'(3));
    take_out();

    // Clear after two beats discards the partial vector.
    vec = '{5, -3, 7, 7, 2, -8, 0, 1, 9, 4, 0, 0};
    send_vec(vec, 2);
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    chk("clr_valid", 64'(s_out_valid), 64'(0));
    chk("clr_index", 64'(s_out_index), 64'(0));
    chk("clr_max", 64'(s_out_max), 64'(0));
    repeat (3) @(posedge Clk);
    #1;
    chk("clr_idle_valid", 64'(s_out_valid), 64'(0));
    vec = '{-5, -2, -9, -4, -7, -3, -6, -8, 0, -1, 33554431, 33554431};
    send_vec(vec, 3);
    chk("clr_next_valid", 64'(s_out_valid), 64'(1));
    chk("clr_next_index", 64'(s_out_index), 64'(8));
    take_out();

    // Reset pulse while beat 2 is being offered.
    vec = '{1, 2, 3, 100, 5, 6, 100, -7, 8, 9, 0, 0};
    send_vec(vec, 1);
    put_beat(vec, 1);
    in_valid = 1'b1;
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("mrst_in_ready", 64'(s_in_ready), 64'(0));
    chk("mrst_max", 64'(s_out_max), 64'(0));
    #1;
    GlobalReset = 1'b1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    chk("mrst_valid", 64'(s_out_valid), 64'(0));
    chk("mrst_ready", 64'(s_in_ready), 64'(1));
    send_vec(vec, 3);
    chk("mrst_next_valid", 64'(s_out_valid), 64'(1));
    chk("mrst_next_index", 64'(s_out_index), 64'(3));
    chk("mrst_next_max", 64'(s_out_max), 64'(m26(100)));
    take_out();

    // Unsigned vs signed compare on the same vector.
    vec = '{67108863, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_vec(vec, 3);
    chk("uns_valid", 64'(u_out_valid), 64'(1));
    chk("uns_index", 64'(u_out_index), 64'(0));
    chk("uns_max", 64'(u_out_max), 64'(m26(67108863)));
    chk("sgn_index", 64'(s_out_index), 64'(1));
    chk("sgn_max", 64'(s_out_max), 64'(m26(1)));
    take_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 26, giving the score width in bits.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, giving the number of scores per vector (>=2).
REQ-003 SHALL have parameter LANES, default 4, giving the scores accepted per input beat (1..NUM_CLASSES).
REQ-004 SHALL have parameter SIGNED_CMP, default 1, where 1 selects two's-complement compare and 0 selects unsigned compare.
REQ-005 SHALL have port Clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port GlobalReset, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have port Clear, input, 1 bit, a synchronous abort that discards the vector in progress.
REQ-008 SHALL have port in_valid, input, 1 bit, marking in_data as valid.
REQ-009 SHALL have port in_ready, output, 1 bit, indicating the block accepts a beat.
REQ-010 SHALL have port in_data, input, NUM_SIZE*LANES bits, where lane k is at [NUM_SIZE*k +: NUM_SIZE].
REQ-011 SHALL have port out_valid, output, 1 bit, marking the result as valid.
REQ-012 SHALL have port out_ready, input, 1 bit, the consumer accept.
REQ-013 SHALL have port out_index, output, IDX_W bits, the winning class index, where IDX_W = max(1, clog2(NUM_CLASSES)).
REQ-014 SHALL have port out_max, output, NUM_SIZE bits, the winning score.

Function
REQ-015 SHALL accept a beat only on a cycle where in_valid and in_ready are both high.
REQ-016 SHALL split a vector into BEATS = ceil(NUM_CLASSES/LANES) beats, where beat b, lane k carries class b*LANES+k.
REQ-017 SHALL ignore lanes whose class index is NUM_CLASSES or greater (final partial beat) in the comparison.
REQ-018 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-019 SHALL, in IDLE, on an accepted beat with BEATS=1, go to DONE; with BEATS>1, load the running max/index from that beat and go to ACCUM.
REQ-020 SHALL, in ACCUM, on each accepted beat, fold the beat into the running max and increment the beat counter; on the final beat it SHALL go to DONE.
REQ-021 SHALL select, within a beat, the maximum lane by strict greater-than in ascending lane order, so the lowest index wins ties.
REQ-022 SHALL replace the running max only when the beat maximum is strictly greater, so the earlier (lower) class index wins ties across beats.
REQ-023 SHALL drive in_ready high in IDLE and ACCUM, and low in DONE.
REQ-024 SHALL, in DONE, drive out_valid high with out_index and out_max held stable until out_ready is high; it then SHALL return to IDLE on the next edge.
REQ-025 SHALL assert out_valid on the cycle after the final beat is accepted (latency 1 cycle).
REQ-026 SHALL, when out_valid and out_ready are both high, allow no new beat that cycle; the next vector's first beat is accepted the following cycle at the earliest.
REQ-027 SHALL, when Clear is high, return to IDLE and zero the beat counter, out_valid, out_index and out_max on the next edge, overriding any handshake in the same cycle.
REQ-028 SHALL keep state unchanged while in_valid is low in ACCUM, with no timeout.
REQ-029 SHALL compute the comparison width as exactly NUM_SIZE bits with no truncation, sign-extending only when SIGNED_CMP=1.

Reset
REQ-030 SHALL, while GlobalReset is low, asynchronously force state=IDLE, beat counter=0, out_valid=0, out_index=0 and out_max=0.
REQ-031 SHALL drive in_ready low while GlobalReset is low, and high from the first edge after release.
REQ-032 SHALL discard a vector interrupted by reset mid-operation, with no partial result emitted.

Structure
REQ-033 SHALL place state encoding, the IDX_W and BEATS derivation functions, and a lane-extract helper in shared package argmax_pkg.
REQ-034 SHALL implement per-beat lane reduction in sub-module argmax_lane_tree (combinational, parametrised NUM_SIZE/LANES/SIGNED_CMP/valid-lane count), producing max and lane offset.
REQ-035 SHALL keep the running max, index and beat counter in argmax_stream only.

Verification
REQ-036 SHALL cover, at default parameters: scores 0..9 = {5,-3,7,7,2,-8,0,1,9,4} in 3 beats -> out_index=8 and out_max=9, one cycle after beat 3.
REQ-037 SHALL cover ties: all scores = -1 -> out_index=0; scores 3 and 6 both = 100 (the maximum) -> out_index=3.
REQ-038 SHALL cover padding: lanes 2,3 of beat 3 = +max (2^25-1) while real scores are <= 0 -> padding is ignored and the index is < 10.
REQ-039 SHALL cover backpressure: out_ready held low for 5 cycles -> result stable, in_ready=0, and a new vector is accepted only after the accept.
REQ-040 SHALL cover Clear asserted after beat 2 and GlobalReset pulsed mid-beat 2 -> no out_valid, and the following clean vector produces the correct result.
REQ-041 SHALL cover SIGNED_CMP=0: scores {0x3FFFFFF, 1, ...} -> out_index=0 (unsigned max), with the same vector under SIGNED_CMP=1 -> a different index.
